// File: rtl/pin_rx_pkg.sv
// Shared defaults and helpers for the pin input receiver.
package pin_rx_pkg;

    localparam int SYNC_STAGES_DEF   = 2;
    localparam int FILTER_CYCLES_DEF = 4;
    localparam int CNT_W_DEF         = 16;

    // Width of the qualify counter; it must hold values up to filter_cycles.
    function automatic int qual_cnt_width(input int filter_cycles);
        return $clog2(filter_cycles + 1);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain flop chain for bringing a single asynchronous bit into the clk domain.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/pin_input_receiver.sv
// Pin receiver: synchronizer, consecutive-sample glitch filter, edge pulses and rising-edge counter.
module pin_input_receiver
    import pin_rx_pkg::*;
#(
    parameter int SYNC_STAGES   = SYNC_STAGES_DEF,
    parameter int FILTER_CYCLES = FILTER_CYCLES_DEF,
    parameter int CNT_W         = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in,
    output logic             out,
    output logic             out_n,
    output logic             rise,
    output logic             fall,
    output logic             glitch,
    output logic [CNT_W-1:0] edge_count
);

    localparam int QW = qual_cnt_width(FILTER_CYCLES);
    localparam logic [QW-1:0] CNT_LAST = QW'(FILTER_CYCLES - 1);

    logic             s;
    logic [QW-1:0]    cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             glitch_q, glitch_d;
    logic [CNT_W-1:0] edge_q, edge_d;

    sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (in),
        .q   (s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            out_q    <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            glitch_q <= 1'b0;
            edge_q   <= '0;
        end else begin
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            glitch_q <= glitch_d;
            edge_q   <= edge_d;
        end
    end

    // cnt==0 is IDLE, any other value is QUALIFY; no separate state register.
    always_comb begin
        cnt_d    = cnt_q;
        out_d    = out_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        glitch_d = 1'b0;
        edge_d   = edge_q;
        if (s != out_q) begin
            if (cnt_q == CNT_LAST) begin
                out_d = s;
                cnt_d = '0;
                if (s) begin
                    rise_d = 1'b1;
                    edge_d = edge_q + CNT_W'(1);
                end else begin
                    fall_d = 1'b1;
                end
            end else begin
                cnt_d = cnt_q + QW'(1);
            end
        end else if (cnt_q != '0) begin
            cnt_d    = '0;
            glitch_d = 1'b1;
        end
    end

    assign out        = out_q;
    assign out_n      = ~out_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign glitch     = glitch_q;
    assign edge_count = edge_q;

endmodule

// File: tb/tb_pin_input_receiver.sv
// Randomized and directed bench for pin_input_receiver against a run-length reference model.
module tb_pin_input_receiver;

    localparam int SYNC = 2;
    localparam int FILT = 4;
    localparam int CW   = 16;
    localparam int CW_S = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_pin = 1'b0;

    logic            out, out_n, rise, fall, glitch;
    logic [CW-1:0]   edge_count;
    logic            s_out, s_out_n, s_rise, s_fall, s_glitch;
    logic [CW_S-1:0] s_edge_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    pin_input_receiver #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in(in_pin),
        .out(out), .out_n(out_n), .rise(rise), .fall(fall), .glitch(glitch),
        .edge_count(edge_count)
    );

    pin_input_receiver #(.SYNC_STAGES(SYNC), .FILTER_CYCLES(FILT), .CNT_W(CW_S)) dut_s (
        .clk(clk), .rst(rst), .in(in_pin),
        .out(s_out), .out_n(s_out_n), .rise(s_rise), .fall(s_fall), .glitch(s_glitch),
        .edge_count(s_edge_count)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference: pin seen SYNC edges late; a new level must persist FILT
    // consecutive evaluation edges, a shorter run is reported as a glitch.
    bit hist [SYNC];
    bit m_s, m_out, m_rise, m_fall, m_glitch;
    int m_run, m_cnt;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
                m_out = 0; m_run = 0; m_cnt = 0;
                m_rise = 0; m_fall = 0; m_glitch = 0;
            end else begin
                m_s = hist[SYNC-1];
                for (int i = SYNC-1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = in_pin;
                m_rise = 0; m_fall = 0; m_glitch = 0;
                if (m_s != m_out) begin
                    m_run++;
                    if (m_run == FILT) begin
                        m_out = m_s;
                        m_run = 0;
                        if (m_s) begin
                            m_rise = 1;
                            m_cnt++;
                        end else begin
                            m_fall = 1;
                        end
                    end
                end else if (m_run > 0) begin
                    m_glitch = 1;
                    m_run = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("out", 32'(out), 32'(m_out));
                check("out_n", 32'(out_n), 32'(!m_out));
                check("rise", 32'(rise), 32'(m_rise));
                check("fall", 32'(fall), 32'(m_fall));
                check("glitch", 32'(glitch), 32'(m_glitch));
                check("edge_count", 32'(edge_count), 32'(m_cnt % (1 << CW)));
                check("pulse_excl", 32'(32'(rise) + 32'(fall) + 32'(glitch) <= 1), 32'd1);
                check("s_out", 32'(s_out), 32'(m_out));
                check("s_edge_count", 32'(s_edge_count), 32'(m_cnt % (1 << CW_S)));
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    int lat, start_cnt, n_glitch, n_edge;

    initial begin
        // Reset with pin low
        cyc(1);
        chk_en = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(20);
        check("rst_out", 32'(out), 32'd0);
        check("rst_out_n", 32'(out_n), 32'd1);
        check("rst_cnt", 32'(edge_count), 32'd0);

        // Clean rise: pulse is visible after the sixth edge following the drive
        in_pin = 1'b1;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rise) begin
                lat = i;
                break;
            end
        end
        check("rise_latency", 32'(lat), 32'd6);
        cyc(8);
        check("rise_cnt", 32'(edge_count), 32'd1);
        check("rise_out", 32'(out), 32'd1);

        // Clean fall
        in_pin = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (fall) begin
                lat = i;
                break;
            end
        end
        check("fall_latency", 32'(lat), 32'd6);
        cyc(8);
        check("fall_cnt", 32'(edge_count), 32'd1);

        // Two-cycle pulse gives a single glitch, no edge
        in_pin = 1'b1;
        cyc(2);
        in_pin = 1'b0;
        n_glitch = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (glitch) n_glitch++;
        end
        check("short_glitches", 32'(n_glitch), 32'd1);
        check("short_out", 32'(out), 32'd0);
        check("short_cnt", 32'(edge_count), 32'd1);

        // 16 clean rising edges: small counter wraps back to its start value
        start_cnt = int'(edge_count);
        for (int k = 0; k < 16; k++) begin
            in_pin = 1'b1;
            cyc(8);
            in_pin = 1'b0;
            cyc(8);
        end
        check("wrap_cnt", 32'(edge_count), 32'(start_cnt + 16));
        check("wrap_small", 32'(s_edge_count), 32'(start_cnt % 16));

        // Async reset while qualifying a rise
        in_pin = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out", 32'(out), 32'd0);
        check("arst_out_n", 32'(out_n), 32'd1);
        check("arst_cnt", 32'(edge_count), 32'd0);
        check("arst_pulses", 32'({rise, fall, glitch}), 32'd0);
        cyc(2);
        rst = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rise) begin
                lat = i;
                break;
            end
        end
        check("arst_rise_latency", 32'(lat), 32'd6);
        check("arst_rise_cnt", 32'(edge_count), 32'd1);
        in_pin = 1'b0;
        cyc(10);

        // Toggle every cycle: only glitches
        n_glitch = 0;
        n_edge = 0;
        for (int i = 0; i < 100; i++) begin
            in_pin = ~in_pin;
            @(negedge clk);
            if (glitch) n_glitch++;
            if (rise || fall) n_edge++;
        end
        in_pin = 1'b0;
        cyc(10);
        check("toggle_edges", 32'(n_edge), 32'd0);
        check("toggle_glitch_seen", 32'(n_glitch > 40), 32'd1);
        check("toggle_out", 32'(out), 32'd0);

        // Random run lengths around the filter threshold
        for (int k = 0; k < 300; k++) begin
            in_pin = 1'($urandom_range(0, 1));
            cyc($urandom_range(1, 7));
        end
        cyc(10);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
